// File: rtl/div_iter.sv
// div_iter: multi-cycle restoring divider (DIV/DIVU) for the execute stage, any WIDTH.
// Latency: start sampled at edge E0 -> ready_o after E0+WIDTH (E0+1 for divide-by-zero).
// Backpressure: result and ready_o held while start_i stays high; start_i ignored while busy.
// Optional feature macro: DIV_EXC_EN adds the div_zero_o flag port.
module div_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
`ifdef DIV_EXC_EN
    output logic                 div_zero_o,
`endif
    output logic                 busy_o
);

    typedef enum logic [1:0] {
        DIV_FREE    = 2'd0,
        DIV_BY_ZERO = 2'd1,
        DIV_ON      = 2'd2,
        DIV_END     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [WIDTH-1:0]    r_rem;     // partial remainder
    logic [WIDTH-1:0]    r_dvd;     // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]    r_dvs;     // divisor magnitude
    logic                r_sign1;   // dividend negative (signed mode only)
    logic                r_sign2;   // divisor negative (signed mode only)
    logic [2*WIDTH-1:0]  r_result;
    logic                r_ready;
`ifdef DIV_EXC_EN
    logic                r_div_zero;
`endif

    logic                w_neg1;
    logic                w_neg2;
    logic [WIDTH-1:0]    w_op1_abs;
    logic [WIDTH-1:0]    w_op2_abs;
    logic [WIDTH:0]      w_shift;
    logic [WIDTH:0]      w_trial;
    logic                w_no_borrow;
    logic [WIDTH-1:0]    w_rem_nxt;
    logic [WIDTH-1:0]    w_quo_nxt;
    logic [WIDTH-1:0]    w_quo_fix;
    logic [WIDTH-1:0]    w_rem_fix;

    // Operand magnitudes; the most-negative value maps to itself, which is the
    // correct unsigned magnitude 2^(WIDTH-1).
    assign w_neg1    = signed_div_i & opdata1_i[WIDTH-1];
    assign w_neg2    = signed_div_i & opdata2_i[WIDTH-1];
    assign w_op1_abs = w_neg1 ? (~opdata1_i + 1'b1) : opdata1_i;
    assign w_op2_abs = w_neg2 ? (~opdata2_i + 1'b1) : opdata2_i;

    // One restoring step. The invariant rem < divisor keeps the shifted value
    // below 2*divisor, so bit WIDTH of the trial difference is exactly the borrow.
    assign w_shift     = {r_rem, r_dvd[WIDTH-1]};
    assign w_trial     = w_shift - {1'b0, r_dvs};
    assign w_no_borrow = ~w_trial[WIDTH];
    assign w_rem_nxt   = w_no_borrow ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_nxt   = {r_dvd[WIDTH-2:0], w_no_borrow};

    // Sign fix-up on the final step: quotient sign is the XOR of operand signs,
    // remainder follows the dividend. Most-negative / -1 wraps naturally.
    assign w_quo_fix = (r_sign1 ^ r_sign2) ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
    assign w_rem_fix = r_sign1 ? (~w_rem_nxt + 1'b1) : w_rem_nxt;

    // Busy reflects the state directly so execute sees it in the launch cycle+1.
    assign busy_o   = (r_state != DIV_FREE);
    assign ready_o  = r_ready;
    assign result_o = r_result;
`ifdef DIV_EXC_EN
    assign div_zero_o = r_div_zero;
`endif

    // Divider FSM: launch, iterate, hold result until execute drops start_i.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= DIV_FREE;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_dvd      <= '0;
            r_dvs      <= '0;
            r_sign1    <= 1'b0;
            r_sign2    <= 1'b0;
            r_result   <= '0;
            r_ready    <= 1'b0;
`ifdef DIV_EXC_EN
            r_div_zero <= 1'b0;
`endif
        end else begin
            case (r_state)
                DIV_FREE: begin
                    if (start_i && !annul_i) begin
                        r_sign1 <= w_neg1;
                        r_sign2 <= w_neg2;
                        r_dvs   <= w_op2_abs;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        if (opdata2_i == '0) begin
                            // Raw dividend is kept: it is returned unmodified as remainder.
                            r_dvd   <= opdata1_i;
                            r_state <= DIV_BY_ZERO;
                        end else begin
                            r_dvd   <= w_op1_abs;
                            r_state <= DIV_ON;
                        end
                    end
                end
                DIV_BY_ZERO: begin
                    r_result   <= {r_dvd, {WIDTH{1'b1}}};
                    r_ready    <= 1'b1;
`ifdef DIV_EXC_EN
                    r_div_zero <= 1'b1;
`endif
                    r_state    <= DIV_END;
                end
                DIV_ON: begin
                    if (annul_i) begin
                        // Flushed: result and ready are still zero from DIV_FREE.
                        r_state <= DIV_FREE;
                    end else begin
                        r_rem <= w_rem_nxt;
                        r_dvd <= w_quo_nxt;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == LAST_CNT) begin
                            r_result <= {w_rem_fix, w_quo_fix};
                            r_ready  <= 1'b1;
                            r_state  <= DIV_END;
                        end
                    end
                end
                DIV_END: begin
                    if (!start_i) begin
                        r_result   <= '0;
                        r_ready    <= 1'b0;
`ifdef DIV_EXC_EN
                        r_div_zero <= 1'b0;
`endif
                        r_state    <= DIV_FREE;
                    end
                end
                default: begin
                    r_state <= DIV_FREE;
                end
            endcase
        end
    end

endmodule
